// File: rtl/arm_execute_unit.sv
// Execute stage: operand-2 shifter, 32-bit ARM ALU, flag register and branch condition check.
// Zero-latency combinational outputs; flags_psr updates on the edge after store_cc. No backpressure.
module arm_execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] rm,
    input  logic [11:0] instr_i11_i0,
    input  logic [1:0]  am,
    input  logic [3:0]  alu_op,
    input  logic        store_cc,
    input  logic        id_b,
    input  logic        id_bl,
    input  logic [3:0]  cond,
    output logic [31:0] shifter_out,
    output logic [31:0] result,
    output logic [3:0]  flags_alu,
    output logic [3:0]  flags_psr,
    output logic        branched,
    output logic        ex_bl
);

    logic [31:0] imm_ext;
    logic [4:0]  imm_rot;
    logic [63:0] imm_dbl;
    logic [4:0]  sh_amt;
    logic [63:0] rm_dbl;

    // Rotates are taken from the low half of a doubled word shifted right.
    assign imm_ext = {24'b0, instr_i11_i0[7:0]};
    assign imm_rot = {instr_i11_i0[11:8], 1'b0};
    assign imm_dbl = {imm_ext, imm_ext} >> imm_rot;
    assign sh_amt  = instr_i11_i0[11:7];
    assign rm_dbl  = {rm, rm} >> sh_amt;

    always_comb begin
        shifter_out = rm;
        case (am)
            2'b00: shifter_out = imm_dbl[31:0];
            2'b01: shifter_out = rm;
            2'b10: shifter_out = {20'b0, instr_i11_i0};
            default: begin
                if (sh_amt == 5'd0) begin
                    shifter_out = rm;
                end else begin
                    case (instr_i11_i0[6:5])
                        2'b00:   shifter_out = rm << sh_amt;
                        2'b01:   shifter_out = rm >> sh_amt;
                        2'b10:   shifter_out = 32'($signed(rm) >>> sh_amt);
                        default: shifter_out = rm_dbl[31:0];
                    endcase
                end
            end
        endcase
    end

    logic        cin;
    logic        arith;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic [31:0] logic_res;

    assign cin = flags_psr[1];

    // All arithmetic ops map onto one adder: subtraction adds the inverted operand.
    always_comb begin
        add_x   = a;
        add_y   = shifter_out;
        add_cin = 1'b0;
        arith   = 1'b1;
        case (alu_op)
            4'b0010, 4'b1010: begin add_y = ~shifter_out; add_cin = 1'b1; end
            4'b0011: begin add_x = shifter_out; add_y = ~a; add_cin = 1'b1; end
            4'b0100, 4'b1011: add_cin = 1'b0;
            4'b0101: add_cin = cin;
            4'b0110: begin add_y = ~shifter_out; add_cin = cin; end
            4'b0111: begin add_x = shifter_out; add_y = ~a; add_cin = cin; end
            default: arith = 1'b0;
        endcase
    end

    always_comb begin
        logic_res = 32'b0;
        case (alu_op)
            4'b0000, 4'b1000: logic_res = a & shifter_out;
            4'b0001, 4'b1001: logic_res = a ^ shifter_out;
            4'b1100:          logic_res = a | shifter_out;
            4'b1101:          logic_res = shifter_out;
            4'b1110:          logic_res = a & ~shifter_out;
            4'b1111:          logic_res = ~shifter_out;
            default:          logic_res = 32'b0;
        endcase
    end

    assign sum    = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};
    assign result = arith ? sum[31:0] : logic_res;

    always_comb begin
        flags_alu[3] = result[31];
        flags_alu[2] = (result == 32'b0);
        if (arith) begin
            flags_alu[1] = sum[32];
            flags_alu[0] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end else begin
            flags_alu[1] = cin;
            flags_alu[0] = flags_psr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_psr <= 4'b0000;
        end else if (store_cc) begin
            flags_psr <= flags_alu;
        end
    end

    // A flag-setting op in EX is visible to the branch in the same cycle.
    logic [3:0] eff;
    logic       n_f, z_f, c_f, v_f;
    logic       cond_true;

    assign eff = store_cc ? flags_alu : flags_psr;
    assign n_f = eff[3];
    assign z_f = eff[2];
    assign c_f = eff[1];
    assign v_f = eff[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = z_f;
            4'b0001: cond_true = !z_f;
            4'b0010: cond_true = c_f;
            4'b0011: cond_true = !c_f;
            4'b0100: cond_true = n_f;
            4'b0101: cond_true = !n_f;
            4'b0110: cond_true = v_f;
            4'b0111: cond_true = !v_f;
            4'b1000: cond_true = c_f && !z_f;
            4'b1001: cond_true = !c_f || z_f;
            4'b1010: cond_true = (n_f == v_f);
            4'b1011: cond_true = (n_f != v_f);
            4'b1100: cond_true = !z_f && (n_f == v_f);
            4'b1101: cond_true = z_f || (n_f != v_f);
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign branched = (id_b | id_bl) & cond_true;
    assign ex_bl    = id_bl & cond_true;

endmodule

// File: tb/tb_arm_execute_unit.sv
// Directed bench for arm_execute_unit: hand-computed vectors checked with immediate assertions.
module tb_arm_execute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, rm;
    logic [11:0] instr_i11_i0;
    logic [1:0]  am;
    logic [3:0]  alu_op;
    logic        store_cc, id_b, id_bl;
    logic [3:0]  cond;
    logic [31:0] shifter_out, result;
    logic [3:0]  flags_alu, flags_psr;
    logic        branched, ex_bl;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    arm_execute_unit dut (
        .clk(clk), .reset(reset), .a(a), .rm(rm), .instr_i11_i0(instr_i11_i0),
        .am(am), .alu_op(alu_op), .store_cc(store_cc), .id_b(id_b), .id_bl(id_bl),
        .cond(cond), .shifter_out(shifter_out), .result(result), .flags_alu(flags_alu),
        .flags_psr(flags_psr), .branched(branched), .ex_bl(ex_bl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; a = 32'd0; rm = 32'd0; instr_i11_i0 = 12'd0; am = 2'b01;
        alu_op = 4'b1101; store_cc = 1'b0; id_b = 1'b0; id_bl = 1'b0; cond = 4'b1110;

        // Reset
        tick();
        check("reset_psr", {28'd0, flags_psr}, 32'h0);
        check("idle_branched", {31'd0, branched}, 32'h0);
        check("idle_ex_bl", {31'd0, ex_bl}, 32'h0);

        // CMP 5,5 sets Z and C
        reset = 1'b1; store_cc = 1'b1; alu_op = 4'b1010; a = 32'd5; am = 2'b01; rm = 32'd5;
        #1;
        check("cmp_flags_alu", {28'd0, flags_alu}, 32'h6);
        check("cmp_psr_before_edge", {28'd0, flags_psr}, 32'h0);
        tick();
        check("cmp_psr_after_edge", {28'd0, flags_psr}, 32'h6);
        store_cc = 1'b0; alu_op = 4'b0100; a = 32'd1; rm = 32'd1;
        tick();
        check("psr_hold", {28'd0, flags_psr}, 32'h6);

        // Immediate rotate and MOV
        am = 2'b00; instr_i11_i0 = 12'h4FF; alu_op = 4'b1101;
        #1;
        check("imm_rot", shifter_out, 32'hFF000000);
        check("mov_result", result, 32'hFF000000);
        check("mov_flags", {28'd0, flags_alu}, 32'hA);
        am = 2'b10; instr_i11_i0 = 12'hABC;
        #1;
        check("imm12", shifter_out, 32'h00000ABC);

        // Register shifts by 1, plus shift amount 0
        am = 2'b11; rm = 32'h80000001;
        instr_i11_i0 = 12'h080; #1; check("lsl1", shifter_out, 32'h00000002);
        instr_i11_i0 = 12'h0A0; #1; check("lsr1", shifter_out, 32'h40000000);
        instr_i11_i0 = 12'h0C0; #1; check("asr1", shifter_out, 32'hC0000000);
        instr_i11_i0 = 12'h0E0; #1; check("ror1", shifter_out, 32'hC0000000);
        instr_i11_i0 = 12'h040; #1; check("asr0", shifter_out, 32'h80000001);
        instr_i11_i0 = 12'hF80; #1; check("lsl31", shifter_out, 32'h80000000);

        // Arithmetic (psr C=1 here)
        am = 2'b01;
        alu_op = 4'b0100; a = 32'h7FFFFFFF; rm = 32'd1; #1;
        check("add_result", result, 32'h80000000);
        check("add_flags", {28'd0, flags_alu}, 32'h9);
        alu_op = 4'b0010; a = 32'd0; rm = 32'd1; #1;
        check("sub_result", result, 32'hFFFFFFFF);
        check("sub_flags", {28'd0, flags_alu}, 32'h8);
        alu_op = 4'b0101; a = 32'd1; rm = 32'd1; #1;
        check("adc_result", result, 32'd3);
        check("adc_flags", {28'd0, flags_alu}, 32'h0);
        alu_op = 4'b0110; a = 32'd5; rm = 32'd2; #1;
        check("sbc_result", result, 32'd3);
        check("sbc_flags", {28'd0, flags_alu}, 32'h2);
        alu_op = 4'b0011; a = 32'd1; rm = 32'd5; #1;
        check("rsb_result", result, 32'd4);
        alu_op = 4'b0111; a = 32'd5; rm = 32'd1; #1;
        check("rsc_result", result, 32'hFFFFFFFC);
        check("rsc_flags", {28'd0, flags_alu}, 32'h8);

        // Branch conditions (psr = Z,C set)
        id_b = 1'b1; cond = 4'b0000; #1;
        check("beq_branched", {31'd0, branched}, 32'h1);
        check("beq_ex_bl", {31'd0, ex_bl}, 32'h0);
        store_cc = 1'b1; alu_op = 4'b0100; a = 32'd1; rm = 32'd1; #1;
        check("beq_bypass", {31'd0, branched}, 32'h0);
        store_cc = 1'b0; #1;
        cond = 4'b1000; #1; check("bhi", {31'd0, branched}, 32'h0);
        cond = 4'b1001; #1; check("bls", {31'd0, branched}, 32'h1);
        cond = 4'b1010; #1; check("bge", {31'd0, branched}, 32'h1);
        cond = 4'b1100; #1; check("bgt", {31'd0, branched}, 32'h0);
        id_b = 1'b0; id_bl = 1'b1; cond = 4'b1110; #1;
        check("bl_branched", {31'd0, branched}, 32'h1);
        check("bl_ex_bl", {31'd0, ex_bl}, 32'h1);
        cond = 4'b1111; #1;
        check("nv_branched", {31'd0, branched}, 32'h0);
        check("nv_ex_bl", {31'd0, ex_bl}, 32'h0);
        id_bl = 1'b0; cond = 4'b0000; #1;
        check("no_branch_instr", {31'd0, branched}, 32'h0);

        // SUB 0x80000000-1 leaves psr = C,V
        store_cc = 1'b1; alu_op = 4'b0010; a = 32'h80000000; rm = 32'd1; #1;
        check("ovf_flags_alu", {28'd0, flags_alu}, 32'h3);
        tick();
        store_cc = 1'b0; #1;
        check("ovf_psr", {28'd0, flags_psr}, 32'h3);
        id_b = 1'b1; cond = 4'b1011; #1;
        check("blt", {31'd0, branched}, 32'h1);
        id_b = 1'b0;

        // Logical op preserves C and V
        alu_op = 4'b0000; a = 32'd0; rm = 32'd5; #1;
        check("and_result", result, 32'h0);
        check("and_flags", {28'd0, flags_alu}, 32'h7);

        // Reset beats store_cc
        reset = 1'b0; store_cc = 1'b1;
        tick();
        check("reset_priority", {28'd0, flags_psr}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
